// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data memory with a req/ack handshake for a
// multicycle CPU's MEM state.
// Optional feature macro: DMEM_RESP_WAIT_STATE_EN
//   undefined -> IDLE -> RESP, ack one cycle after acceptance
//   defined   -> IDLE -> WAIT (WAIT cycles) -> RESP, ack WAIT+1 cycles after acceptance
// Handshake: req is held high by the requester until ack. An access is
// accepted at a rising edge where state is IDLE and req=1. ack is a one-cycle
// pulse in the RESP cycle, and err/rdata are valid with it. busy is high from
// acceptance until the edge that leaves RESP. Inputs are ignored while busy.
module dmem_resp #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] mem [DEPTH];

  logic        ack_q;
  logic        busy_q;
  logic        err_q;
  logic [31:0] rdata_q;

  // Access attributes used at the edge that enters RESP.
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_mis;
  logic          enter_resp;
  logic          mem_we;

`ifdef DMEM_RESP_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;

  // With wait states, the commit happens later from the captured copy.
  assign acc_we     = we_q;
  assign acc_addr   = addr_q;
  assign acc_wdata  = wdata_q;
  assign enter_resp = (state_q == S_WAIT) && (cnt_q == 4'd0);
`else
  // Without wait states, the acceptance edge is also the RESP-entry edge,
  // so the values sampled at that edge are the captured values.
  assign acc_we     = we;
  assign acc_addr   = addr;
  assign acc_wdata  = wdata;
  assign enter_resp = (state_q == S_IDLE) && req;
`endif

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_mis = |acc_addr[1:0];
  // A reset at the RESP-entry edge aborts the access, so no write happens.
  assign mem_we  = enter_resp && acc_we && !acc_mis && !rst;

  // Upper address bits are intentionally ignored, so the address space wraps.
  logic unused_ok;
  assign unused_ok = ^{acc_addr[31:AW+2], 4'(WAIT)};

  // Control FSM, plus the registered ack/busy/err/rdata outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_RESP_WAIT_STATE_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            busy_q  <= 1'b1;
`ifdef DMEM_RESP_WAIT_STATE_EN
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= WAIT_LOAD;
            state_q <= S_WAIT;
`else
            state_q <= S_RESP;
`endif
          end
        end
`ifdef DMEM_RESP_WAIT_STATE_EN
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        S_RESP: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Completion: ack/err for one cycle; loads refresh rdata, stores keep it.
      if (enter_resp) begin
        ack_q <= 1'b1;
        err_q <= acc_mis;
        if (!acc_we) begin
          rdata_q <= acc_mis ? 32'h0 : mem[acc_idx];
        end
      end
    end
  end

  // Storage: written only on an aligned store at RESP entry, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rdata       = rdata_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, the number of 32-bit words in storage; it SHALL be a power of two, 4..4096.
REQ-002 SHALL have parameter WAIT, default 2, the wait-state cycles inserted per access when MEM_WAIT_EN is defined; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; one clock, synchronous, active-high.
REQ-005 SHALL have port req, input, 1 bit, access request from the multicycle CPU's MEM state, held high until ack.
REQ-006 SHALL have port we, input, 1 bit: 1 = store (sw), 0 = load (lw).
REQ-007 SHALL have port addr, input, 32 bits, byte address.
REQ-008 SHALL have port wdata, input, 32 bits, store data.
REQ-009 SHALL have port rdata, output, 32 bits, load data.
REQ-010 SHALL have port ack, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1 bit, high while an accepted access is outstanding.
REQ-012 SHALL have port err, output, 1 bit, misaligned-access flag, valid with ack.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP, all registered.
REQ-014 IDLE with req=1 at a rising edge SHALL accept the access: capture we, addr and wdata, set busy=1, and go to WAIT if MEM_WAIT_EN is defined, else RESP.
REQ-015 WAIT SHALL load a counter with WAIT-1 on entry, decrement it each cycle, and go to RESP on the edge where the counter equals 0.
REQ-016 RESP SHALL assert ack=1 for exactly one cycle, then return to IDLE; busy SHALL drop at that same edge.
REQ-017 Latency: ack SHALL be high in the cycle following the acceptance edge without MEM_WAIT_EN, and WAIT+1 cycles after the acceptance edge with it.
REQ-018 While busy=1, changes on req, we, addr and wdata SHALL be ignored; only the captured values are used.
REQ-019 A new access SHALL be accepted no earlier than the first IDLE cycle after ack (at most one access per 2 cycles); req still high during RESP SHALL NOT count as a new request.
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2]; the upper address bits SHALL be ignored, so the address space wraps modulo DEPTH*4.
REQ-021 On a store, memory SHALL be written with the captured wdata at the edge that enters RESP.
REQ-022 On a load, rdata SHALL present the word read at the captured index during the ack cycle and SHALL hold that value until the next ack.
REQ-023 If the captured addr[1:0] != 0: err=1 during ack, no memory write, and rdata=0 for a load; otherwise err=0.
REQ-024 Memory contents SHALL be uninitialised (X) until written; no read-before-write protection.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, wait counter=0, ack=0, busy=0, err=0, rdata=32'h0.
REQ-026 Reset mid-access (in WAIT or RESP) SHALL abort the access: no write and no ack; a write already committed on entry to RESP SHALL remain.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 With rst=1 and req=1 together, the request SHALL be ignored; acceptance becomes possible on the first edge with rst=0.

Configuration
REQ-029 Macro DMEM_RESP_WAIT_STATE_EN: when defined, the WAIT state and counter SHALL be compiled in and latency follows REQ-015 and REQ-017.
REQ-030 When DMEM_RESP_WAIT_STATE_EN is undefined, the WAIT state and counter SHALL be absent, the WAIT parameter has no effect, and every access completes with 1-cycle latency.
(REQ-014, REQ-015 and REQ-017 use MEM_WAIT_EN as shorthand for DMEM_RESP_WAIT_STATE_EN.)

Verification
REQ-031 Macro off: store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10 -> each ack 1 cycle after acceptance; load rdata=0xDEADBEEF, err=0.
REQ-032 Macro on, WAIT=2: load addr=0x10 -> busy high for 3 cycles, ack in the 3rd cycle after acceptance, rdata=0xDEADBEEF.
REQ-033 Store addr=0x13, wdata=0x12345678 -> ack with err=1; a following load of 0x10 still returns its previous value.
REQ-034 DEPTH=256: store addr=0x400, wdata=0xA5A5A5A5; load addr=0x0 -> rdata=0xA5A5A5A5 (wrap-around).
REQ-035 Macro on: assert rst in the WAIT cycle of a store to 0x20 -> no ack, word 0x20 unchanged, busy=0 in the next cycle.
REQ-036 Keep req high continuously across two accesses -> exactly one ack per access, separated by at least one IDLE cycle; wdata change while busy has no effect.
